// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the writeback request type used by the
// regfile write-port arbiter.
package cpu_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 32;
  localparam int unsigned DW     = 64;
  localparam int unsigned ZR_IDX = 31;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DW-1:0]     data;
  } wb_req_t;

  // Which requester currently holds priority when both are valid.
  typedef enum logic {
    RR_SRC0 = 1'b0,
    RR_SRC1 = 1'b1
  } rr_sel_e;

  function automatic logic is_zero_reg(input logic [REG_AW-1:0] addr);
    return addr == REG_AW'(ZR_IDX);
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority pointer
// flips to the other source after every accepted grant and holds when idle.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_block,
  output logic [1:0] o_gnt
);

  rr_sel_e r_ptr;
  rr_sel_e w_ptr_nxt;

  always_comb begin
    o_gnt     = '0;
    w_ptr_nxt = r_ptr;
    if (!reset && !i_block) begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = (r_ptr == RR_SRC0) ? 2'b01 : 2'b10;
        default: o_gnt = '0;
      endcase
    end
    // Every grant is an accepted transfer, so the pointer moves to the loser.
    if (o_gnt[1])
      w_ptr_nxt = RR_SRC0;
    else if (o_gnt[0])
      w_ptr_nxt = RR_SRC1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_ptr <= RR_SRC0;
    else
      r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between ALU (src0) and load (src1) writeback,
// registers the winning write, and bypasses it onto both read ports.
module regfile_wr_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned NREG = cpu_pkg::NREG,
  parameter int unsigned DW   = cpu_pkg::DW,
  parameter int unsigned ZR   = cpu_pkg::ZR_IDX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s0_valid,
  input  logic [$clog2(NREG)-1:0] s0_addr,
  input  logic [DW-1:0]           s0_data,
  output logic                    s0_ready,
  input  logic                    s1_valid,
  input  logic [$clog2(NREG)-1:0] s1_addr,
  input  logic [DW-1:0]           s1_data,
  output logic                    s1_ready,
  input  logic                    stall,
  output logic                    RegWrite,
  output logic [$clog2(NREG)-1:0] WriteRegister,
  output logic [DW-1:0]           WriteData,
  input  logic [$clog2(NREG)-1:0] rd1_addr,
  input  logic [$clog2(NREG)-1:0] rd2_addr,
  input  logic [DW-1:0]           rf_rd1,
  input  logic [DW-1:0]           rf_rd2,
  output logic [DW-1:0]           rd1_data,
  output logic [DW-1:0]           rd2_data
);

  localparam int unsigned AW = $clog2(NREG);
  localparam logic [AW-1:0] ZR_A = AW'(ZR);

  logic [1:0]    w_gnt;
  logic          w_fire;
  wb_req_t       w_sel;
  logic          r_regwrite;
  logic [AW-1:0] r_wreg;
  logic [DW-1:0] r_wdata;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req   ({s1_valid, s0_valid}),
    .i_block (stall),
    .o_gnt   (w_gnt)
  );

  assign s0_ready = w_gnt[0];
  assign s1_ready = w_gnt[1];
  assign w_fire   = |w_gnt;

  always_comb begin
    w_sel = '0;
    if (w_gnt[1]) begin
      w_sel.addr = s1_addr;
      w_sel.data = s1_data;
    end else begin
      w_sel.addr = s0_addr;
      w_sel.data = s0_data;
    end
  end

  // Zero-register writes still handshake; only the write enable is suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regwrite <= 1'b0;
      r_wreg     <= '0;
      r_wdata    <= '0;
    end else if (w_fire) begin
      r_regwrite <= (w_sel.addr != ZR_A);
      r_wreg     <= w_sel.addr;
      r_wdata    <= w_sel.data;
    end else begin
      r_regwrite <= 1'b0;
    end
  end

  assign RegWrite      = r_regwrite;
  assign WriteRegister = r_wreg;
  assign WriteData     = r_wdata;

  // The registered write lands in the regfile only at the next edge, so a
  // read of the same register this cycle must see the in-flight value.
  always_comb begin
    rd1_data = rf_rd1;
    if (rd1_addr == ZR_A)
      rd1_data = '0;
    else if (r_regwrite && (rd1_addr == r_wreg))
      rd1_data = r_wdata;
  end

  always_comb begin
    rd2_data = rf_rd2;
    if (rd2_addr == ZR_A)
      rd2_data = '0;
    else if (r_regwrite && (rd2_addr == r_wreg))
      rd2_data = r_wdata;
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: arbitration order, output stage,
// zero register, stall, same-destination ordering and reset behaviour.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s0_valid = 1'b0;
  logic [4:0]  s0_addr = '0;
  logic [63:0] s0_data = '0;
  logic        s0_ready;
  logic        s1_valid = 1'b0;
  logic [4:0]  s1_addr = '0;
  logic [63:0] s1_data = '0;
  logic        s1_ready;
  logic        stall = 1'b0;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  rd1_addr = '0;
  logic [4:0]  rd2_addr = '0;
  logic [63:0] rf_rd1 = '0;
  logic [63:0] rf_rd2 = '0;
  logic [63:0] rd1_data;
  logic [63:0] rd2_data;

  int checks = 0;
  int errors = 0;
  logic [63:0] shadow [32];

  regfile_wr_arbiter #(.NREG(32), .DW(64), .ZR(31)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(s1_ready),
    .stall(stall),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rd1_data(rd1_data), .rd2_data(rd2_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (RegWrite) shadow[WriteRegister] <= WriteData;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; s0_valid = 1'b1; s1_valid = 1'b1;
    s0_addr = 5'd1; s1_addr = 5'd2; s0_data = 64'h1; s1_data = 64'h2;
    #1;
    checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL rst_s0_ready got %0b exp 0", s0_ready); end
    checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL rst_s1_ready got %0b exp 0", s1_ready); end
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %0b exp 0", RegWrite); end
    checks++; if (WriteRegister !== 5'd0) begin errors++; $display("FAIL rst_wreg got %0d exp 0", WriteRegister); end
    checks++; if (WriteData !== 64'h0) begin errors++; $display("FAIL rst_wdata got %0h exp 0", WriteData); end
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 64'h3E7;
    rd1_addr = 5'd5; rf_rd1 = 64'h55; rd2_addr = 5'd6; rf_rd2 = 64'h66;
    #1;
    checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL single_s0_ready got %0b exp 1", s0_ready); end
    checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL single_s1_ready got %0b exp 0", s1_ready); end
    checks++; if (rd1_data !== 64'h55) begin errors++; $display("FAIL single_rd1_pre got %0h exp 55", rd1_data); end
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL single_regwrite got %0b exp 1", RegWrite); end
    checks++; if (WriteRegister !== 5'd5) begin errors++; $display("FAIL single_wreg got %0d exp 5", WriteRegister); end
    checks++; if (WriteData !== 64'h3E7) begin errors++; $display("FAIL single_wdata got %0h exp 3e7", WriteData); end
    checks++; if (rd1_data !== 64'h3E7) begin errors++; $display("FAIL single_rd1_bypass got %0h exp 3e7", rd1_data); end
    checks++; if (rd2_data !== 64'h66) begin errors++; $display("FAIL single_rd2_miss got %0h exp 66", rd2_data); end
    @(negedge clk);
    s0_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL single_regwrite_clr got %0b exp 0", RegWrite); end
    checks++; if (WriteData !== 64'h3E7) begin errors++; $display("FAIL single_wdata_hold got %0h exp 3e7", WriteData); end
    checks++; if (rd1_data !== 64'h55) begin errors++; $display("FAIL single_rd1_post got %0h exp 55", rd1_data); end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_reg;
    do_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 5'd1; s0_data = 64'hA;
    s1_valid = 1'b1; s1_addr = 5'd2; s1_data = 64'hB;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (s0_ready !== (i % 2 == 0)) begin errors++; $display("FAIL rr_s0_ready[%0d] got %0b exp %0b", i, s0_ready, (i % 2 == 0)); end
      checks++; if (s1_ready !== (i % 2 == 1)) begin errors++; $display("FAIL rr_s1_ready[%0d] got %0b exp %0b", i, s1_ready, (i % 2 == 1)); end
      exp_reg = (i % 2 == 0) ? 5'd1 : 5'd2;
      @(posedge clk); #1;
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL rr_regwrite[%0d] got %0b exp 1", i, RegWrite); end
      checks++; if (WriteRegister !== exp_reg) begin errors++; $display("FAIL rr_wreg[%0d] got %0d exp %0d", i, WriteRegister, exp_reg); end
    end
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic test_zero_reg();
    do_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 64'h1;
    #1;
    checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL zr_s0_first got %0b exp 1", s0_ready); end
    @(negedge clk);
    s0_valid = 1'b0;
    s1_valid = 1'b1; s1_addr = 5'd31; s1_data = 64'hFFFF;
    rd2_addr = 5'd31; rf_rd2 = 64'hAAAA;
    #1;
    checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL zr_s1_ready got %0b exp 1", s1_ready); end
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL zr_regwrite got %0b exp 0", RegWrite); end
    checks++; if (rd2_data !== 64'h0) begin errors++; $display("FAIL zr_rd2 got %0h exp 0", rd2_data); end
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 5'd9; s0_data = 64'h99;
    s1_valid = 1'b1; s1_addr = 5'd8; s1_data = 64'h88;
    #1;
    checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL zr_ptr_adv_s0 got %0b exp 1", s0_ready); end
    checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL zr_ptr_adv_s1 got %0b exp 0", s1_ready); end
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0; rd2_addr = 5'd0;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 64'h33;
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL stall_pre_regwrite got %0b exp 1", RegWrite); end
    @(negedge clk);
    stall = 1'b1;
    s0_addr = 5'd10; s0_data = 64'hA0;
    s1_valid = 1'b1; s1_addr = 5'd11; s1_data = 64'hB0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %0b%0b exp 00", i, s1_ready, s0_ready); end
      @(posedge clk); #1;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL stall_regwrite[%0d] got %0b exp 0", i, RegWrite); end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    checks++; if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin errors++; $display("FAIL stall_release got %0b%0b exp 10", s1_ready, s0_ready); end
    @(posedge clk); #1;
    checks++; if (WriteData !== 64'hB0) begin errors++; $display("FAIL stall_wdata1 got %0h exp b0", WriteData); end
    @(negedge clk);
    s1_valid = 1'b0;
    #1;
    checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL stall_s0_after got %0b exp 1", s0_ready); end
    @(posedge clk); #1;
    checks++; if (WriteRegister !== 5'd10) begin errors++; $display("FAIL stall_wreg2 got %0d exp 10", WriteRegister); end
    @(negedge clk);
    s0_valid = 1'b0;
  endtask

  task automatic test_same_dest();
    do_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 64'h11;
    s1_valid = 1'b1; s1_addr = 5'd7; s1_data = 64'h22;
    rd1_addr = 5'd7; rd2_addr = 5'd7; rf_rd1 = 64'h0; rf_rd2 = 64'h0;
    #1;
    checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin errors++; $display("FAIL same_first got %0b%0b exp 01", s1_ready, s0_ready); end
    @(posedge clk); #1;
    checks++; if (WriteData !== 64'h11) begin errors++; $display("FAIL same_wdata1 got %0h exp 11", WriteData); end
    checks++; if (rd1_data !== 64'h11 || rd2_data !== 64'h11) begin errors++; $display("FAIL same_bypass1 got %0h/%0h exp 11/11", rd1_data, rd2_data); end
    @(negedge clk);
    s0_valid = 1'b0;
    #1;
    checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL same_second got %0b exp 1", s1_ready); end
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b1 || WriteData !== 64'h22) begin errors++; $display("FAIL same_wdata2 got %0b/%0h exp 1/22", RegWrite, WriteData); end
    checks++; if (rd1_data !== 64'h22 || rd2_data !== 64'h22) begin errors++; $display("FAIL same_bypass2 got %0h/%0h exp 22/22", rd1_data, rd2_data); end
    @(negedge clk);
    s1_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (shadow[7] !== 64'h22) begin errors++; $display("FAIL same_shadow got %0h exp 22", shadow[7]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 5'd4; s0_data = 64'h44;
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL midrst_pre got %0b exp 1", RegWrite); end
    @(negedge clk);
    reset = 1'b1; s0_valid = 1'b0;
    s1_valid = 1'b1; s1_addr = 5'd9; s1_data = 64'h99;
    #1;
    checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL midrst_s1_ready got %0b exp 0", s1_ready); end
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 64'h0) begin errors++; $display("FAIL midrst_out got %0b/%0d/%0h exp 0/0/0", RegWrite, WriteRegister, WriteData); end
    @(negedge clk);
    reset = 1'b0;
    s0_valid = 1'b1; s0_addr = 5'd4; s0_data = 64'h45;
    rd1_addr = 5'd4; rf_rd1 = 64'h1234;
    #1;
    checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin errors++; $display("FAIL midrst_ptr got %0b%0b exp 01", s1_ready, s0_ready); end
    checks++; if (rd1_data !== 64'h1234) begin errors++; $display("FAIL midrst_rd1 got %0h exp 1234", rd1_data); end
    @(posedge clk); #1;
    checks++; if (WriteData !== 64'h45) begin errors++; $display("FAIL midrst_wdata got %0h exp 45", WriteData); end
    @(negedge clk);
    s0_valid = 1'b0;
    #1;
    checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL midrst_regrant got %0b exp 1", s1_ready); end
    @(posedge clk); #1;
    checks++; if (WriteRegister !== 5'd9 || WriteData !== 64'h99) begin errors++; $display("FAIL midrst_s1_write got %0d/%0h exp 9/99", WriteRegister, WriteData); end
    @(negedge clk);
    s1_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_reg();
    test_stall();
    test_same_dest();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
